// File: rtl/snake_pkg.sv
// Shared snake game types: tiles, map frame and game modes.
// Used by game core, draw and the frame scheduler.
package snake_pkg;

  localparam int MAP_W = 16;
  localparam int MAP_H = 12;

  typedef enum logic [2:0] {
    EMPTY,
    WALL,
    SNAKE1,
    SNAKE2,
    POINT
  } tile_t;

  typedef enum logic [2:0] {
    MENU,
    GAME,
    WIN,
    LOSE,
    DRAW,
    ERROR
  } game_mode;

  typedef struct packed {
    tile_t [MAP_H-1:0][MAP_W-1:0] tiles;
  } map_s;

endpackage

// File: rtl/frame_sync_ctl_edge.sv
// Rising-edge detector; delay register resets high so a level
// that is already high after reset never reads as an edge.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // one-cycle delay of the input level
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b1;
    else     d_q <= d;
  end

  assign rise = d && !d_q;

endmodule

// File: rtl/frame_sync_ctl.sv
// Frame-synchronous publish of map and mode from game core to
// draw; updates land only on the rising edge of vblank.
import snake_pkg::*;

module frame_sync_ctl #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vblnk,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_x,
  input  logic [7:0]             wr_y,
  input  tile_t                  wr_tile,
  input  logic                   commit_req,
  input  logic                   mode_valid,
  input  game_mode               mode_in,
  output map_s                   map,
  output game_mode               mode,
  output logic                   busy,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_oob
);

  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam logic [7:0] XLIM = 8'(MAP_W);
  localparam logic [7:0] YLIM = 8'(MAP_H);

  typedef enum logic {
    COLLECT,
    PENDING
  } state_t;

  state_t   state;
  state_t   state_nx;
  logic     fedge;
  logic     wr_acc;
  logic     in_rng;
  logic     publish;
  map_s     back;
  game_mode pend;

  edge_detect_rise u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (vblnk),
    .rise (fedge)
  );

  assign wr_acc = wr_valid && wr_ready;
  assign in_rng = (wr_x < XLIM) && (wr_y < YLIM);

  // commit FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nx;
  end

  // next state and handshake outputs; an edge seen while still
  // collecting is ignored, so a same-cycle commit waits a frame
  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    busy     = 1'b0;
    publish  = 1'b0;
    unique case (state)
      COLLECT: begin
        wr_ready = 1'b1;
        if (commit_req) state_nx = PENDING;
      end
      PENDING: begin
        busy = 1'b1;
        if (fedge) begin
          publish  = 1'b1;
          state_nx = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  // back buffer persists across commits; only changed tiles rewritten
  always_ff @(posedge clk) begin
    if (rst) begin
      back    <= '0;
      err_oob <= 1'b0;
    end else begin
      err_oob <= wr_acc && !in_rng;
      if (wr_acc && in_rng)
        back.tiles[wr_y[YW-1:0]][wr_x[XW-1:0]] <= wr_tile;
    end
  end

  // front map swap, tick and published-frame count
  always_ff @(posedge clk) begin
    if (rst) begin
      map        <= '0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= publish;
      if (publish) begin
        map       <= back;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // mode follows pending value on every frame edge, commit or not
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= MENU;
      mode <= MENU;
    end else begin
      if (mode_valid) pend <= mode_in;
      if (fedge)      mode <= pend;
    end
  end

endmodule
